// File: rtl/sram_arbiter.sv
// Two-master arbiter for the external 16-bit SRAM: display reads have priority,
// HDR read/write is best-effort with a starvation bound and write->read turnaround.
module sram_arbiter #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_disp_req,
  input  logic [ADDR_W-1:0] i_disp_addr,
  output logic              o_disp_ready,
  output logic [DATA_W-1:0] o_disp_data,
  output logic              o_disp_valid,
  input  logic              i_hdr_req,
  input  logic              i_hdr_we,
  input  logic [ADDR_W-1:0] i_hdr_addr,
  input  logic [DATA_W-1:0] i_hdr_wdata,
  output logic              o_hdr_ack,
  output logic [DATA_W-1:0] o_hdr_rdata,
  output logic              o_hdr_rvalid,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  inout  wire  [DATA_W-1:0] io_SRAM_DQ,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_LB_N,
  output logic              o_SRAM_UB_N
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_TURN} state_t;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  state_t            r_state, w_next;
  logic [7:0]        r_starve;
  logic              w_override, w_grant_disp, w_grant_hdr;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic              r_tag, w_tag_nxt;
  logic              r_ce_n, r_oe_n, r_we_n, r_bl_n;
  logic              w_ce_n, w_oe_n, w_we_n, w_bl_n;
  logic [DATA_W-1:0] r_disp_data, r_hdr_rdata;
  logic              r_disp_valid, r_hdr_rvalid;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Grant decision and next state
  always_comb begin
    w_override   = (r_starve == STARVE_LIM) && i_hdr_req;
    w_grant_disp = 1'b0;
    w_grant_hdr  = 1'b0;
    w_next       = S_IDLE;
    if (!i_rst) begin
      if (r_state == S_WRITE) begin
        // Only another write may follow a write without turning the bus around
        if (i_hdr_req && i_hdr_we) begin
          w_grant_hdr = 1'b1;
          w_next      = S_WRITE;
        end else begin
          w_next = S_TURN;
        end
      end else if (w_override) begin
        w_grant_hdr = 1'b1;
        w_next      = i_hdr_we ? S_WRITE : S_READ;
      end else if (i_disp_req) begin
        w_grant_disp = 1'b1;
        w_next       = S_READ;
      end else if (i_hdr_req) begin
        w_grant_hdr = 1'b1;
        w_next      = i_hdr_we ? S_WRITE : S_READ;
      end
    end
  end

  // Pin controls and datapath for the next cycle
  always_comb begin
    w_ce_n = 1'b1;
    w_oe_n = 1'b1;
    w_we_n = 1'b1;
    w_bl_n = 1'b1;
    case (w_next)
      S_READ:  begin w_ce_n = 1'b0; w_oe_n = 1'b0; w_bl_n = 1'b0; end
      S_WRITE: begin w_ce_n = 1'b0; w_we_n = 1'b0; w_bl_n = 1'b0; end
      default: ;
    endcase
    w_addr_nxt  = w_grant_disp ? i_disp_addr :
                  w_grant_hdr  ? i_hdr_addr  : r_addr;
    w_wdata_nxt = (w_grant_hdr && i_hdr_we) ? i_hdr_wdata : r_wdata;
    w_tag_nxt   = w_grant_hdr;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr       <= '0;
      r_wdata      <= '0;
      r_tag        <= 1'b0;
      r_ce_n       <= 1'b1;
      r_oe_n       <= 1'b1;
      r_we_n       <= 1'b1;
      r_bl_n       <= 1'b1;
      r_starve     <= '0;
      r_disp_data  <= '0;
      r_hdr_rdata  <= '0;
      r_disp_valid <= 1'b0;
      r_hdr_rvalid <= 1'b0;
    end else begin
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_tag        <= w_tag_nxt;
      r_ce_n       <= w_ce_n;
      r_oe_n       <= w_oe_n;
      r_we_n       <= w_we_n;
      r_bl_n       <= w_bl_n;
      r_disp_valid <= 1'b0;
      r_hdr_rvalid <= 1'b0;
      if (!i_hdr_req || w_grant_hdr) r_starve <= '0;
      else if (r_starve != STARVE_LIM) r_starve <= r_starve + 8'd1;
      // Tag routes the DQ sample of the read on the pins to its requester
      if (r_state == S_READ) begin
        if (r_tag) begin
          r_hdr_rdata  <= io_SRAM_DQ;
          r_hdr_rvalid <= 1'b1;
        end else begin
          r_disp_data  <= io_SRAM_DQ;
          r_disp_valid <= 1'b1;
        end
      end
    end
  end

  assign io_SRAM_DQ   = (r_state == S_WRITE) ? r_wdata : {DATA_W{1'bz}};
  assign o_disp_ready = !i_rst && (r_state != S_WRITE) && !w_override;
  assign o_hdr_ack    = w_grant_hdr;
  assign o_disp_data  = r_disp_data;
  assign o_disp_valid = r_disp_valid;
  assign o_hdr_rdata  = r_hdr_rdata;
  assign o_hdr_rvalid = r_hdr_rvalid;
  assign o_SRAM_ADDR  = r_addr;
  assign o_SRAM_CE_N  = r_ce_n;
  assign o_SRAM_OE_N  = r_oe_n;
  assign o_SRAM_WE_N  = r_we_n;
  assign o_SRAM_LB_N  = r_bl_n;
  assign o_SRAM_UB_N  = r_bl_n;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of the arbitration rules and an SRAM model.
module tb_sram_arbiter;

  localparam int STARVE = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        dreq, hreq, hwe;
  logic [19:0] daddr, haddr;
  logic [15:0] hwdata;
  logic        o_disp_ready, o_disp_valid, o_hdr_ack, o_hdr_rvalid;
  logic [15:0] o_disp_data, o_hdr_rdata;
  logic [19:0] sram_addr;
  logic        ce_n, oe_n, we_n, lb_n, ub_n;
  wire  [15:0] sram_dq;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  sram_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_disp_req(dreq), .i_disp_addr(daddr), .o_disp_ready(o_disp_ready),
    .o_disp_data(o_disp_data), .o_disp_valid(o_disp_valid),
    .i_hdr_req(hreq), .i_hdr_we(hwe), .i_hdr_addr(haddr), .i_hdr_wdata(hwdata),
    .o_hdr_ack(o_hdr_ack), .o_hdr_rdata(o_hdr_rdata), .o_hdr_rvalid(o_hdr_rvalid),
    .o_SRAM_ADDR(sram_addr), .io_SRAM_DQ(sram_dq),
    .o_SRAM_CE_N(ce_n), .o_SRAM_OE_N(oe_n), .o_SRAM_WE_N(we_n),
    .o_SRAM_LB_N(lb_n), .o_SRAM_UB_N(ub_n)
  );

  // SRAM model: unwritten words read back as their own address
  logic [15:0] sram_mem [0:(1<<20)-1];
  wire         sram_drv = !ce_n && !oe_n && we_n;
  wire  [15:0] sram_rd  = sram_mem[sram_addr];
  assign sram_dq = sram_drv ? sram_rd : 16'hzzzz;

  initial for (int i = 0; i < (1 << 20); i++) sram_mem[i] = i[15:0];

  always @(posedge clk) if (!ce_n && !we_n) sram_mem[sram_addr] <= sram_dq;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; dreq = 1'b1; hreq = 1'b1; hwe = 1'b0;
    daddr = 20'h1; haddr = 20'h2; hwdata = '0;
    next_cycle(); next_cycle();
    @(negedge clk);
    n_chk++; if ({ce_n, oe_n, we_n, lb_n, ub_n} !== 5'b11111)
      $display("FAIL rst_ctrl: got %b want 11111", {ce_n, oe_n, we_n, lb_n, ub_n}); else n_pass++;
    n_chk++; if (sram_addr !== 20'h0) $display("FAIL rst_addr: got %h want 0", sram_addr); else n_pass++;
    n_chk++; if (o_disp_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", o_disp_ready); else n_pass++;
    n_chk++; if (o_hdr_ack !== 1'b0) $display("FAIL rst_ack: got %b want 0", o_hdr_ack); else n_pass++;
    n_chk++; if ({o_disp_valid, o_hdr_rvalid} !== 2'b00)
      $display("FAIL rst_valid: got %b want 00", {o_disp_valid, o_hdr_rvalid}); else n_pass++;
    n_chk++; if ({o_disp_data, o_hdr_rdata} !== 32'h0)
      $display("FAIL rst_data: got %h want 0", {o_disp_data, o_hdr_rdata}); else n_pass++;
    next_cycle();
    rst = 1'b0; dreq = 1'b0; hreq = 1'b0;
    @(negedge clk);
    n_chk++; if (o_disp_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", o_disp_ready); else n_pass++;
    next_cycle();
  endtask

  task automatic test_disp_burst();
    for (int i = 0; i < 644; i++) begin
      dreq = (i < 640); daddr = 20'(i);
      @(negedge clk);
      if (i < 640) begin
        n_chk++; if (o_disp_ready !== 1'b1) $display("FAIL burst_ready i=%0d: got %b want 1", i, o_disp_ready); else n_pass++;
      end
      if (i >= 1 && i <= 640) begin
        n_chk++; if (sram_addr !== 20'(i - 1) || oe_n !== 1'b0)
          $display("FAIL burst_pins i=%0d: got addr %h oe_n %b want %h 0", i, sram_addr, oe_n, 20'(i - 1)); else n_pass++;
      end
      n_chk++; if (o_disp_valid !== (i >= 2 && i < 642))
        $display("FAIL burst_valid i=%0d: got %b want %b", i, o_disp_valid, (i >= 2 && i < 642)); else n_pass++;
      if (i >= 2 && i < 642) begin
        n_chk++; if (o_disp_data !== 16'(i - 2))
          $display("FAIL burst_data i=%0d: got %h want %h", i, o_disp_data, 16'(i - 2)); else n_pass++;
      end
      n_chk++; if (o_hdr_rvalid !== 1'b0) $display("FAIL burst_hdr_strobe i=%0d: got 1 want 0", i); else n_pass++;
      next_cycle();
    end
    dreq = 1'b0;
  endtask

  task automatic test_hdr_write_read();
    hreq = 1'b1; hwe = 1'b1; haddr = 20'h12345; hwdata = 16'hBEEF;
    @(negedge clk);
    n_chk++; if (o_hdr_ack !== 1'b1) $display("FAIL wr_ack: got %b want 1", o_hdr_ack); else n_pass++;
    next_cycle();
    hwe = 1'b0;
    @(negedge clk);
    n_chk++; if (o_hdr_ack !== 1'b0) $display("FAIL rd_in_write_ack: got %b want 0", o_hdr_ack); else n_pass++;
    n_chk++; if (o_disp_ready !== 1'b0) $display("FAIL write_ready: got %b want 0", o_disp_ready); else n_pass++;
    n_chk++; if (we_n !== 1'b0 || ce_n !== 1'b0 || oe_n !== 1'b1 || sram_addr !== 20'h12345)
      $display("FAIL write_pins: got we_n %b ce_n %b oe_n %b addr %h", we_n, ce_n, oe_n, sram_addr); else n_pass++;
    n_chk++; if (sram_dq !== 16'hBEEF) $display("FAIL write_dq: got %h want beef", sram_dq); else n_pass++;
    next_cycle();
    @(negedge clk);
    n_chk++; if (o_hdr_ack !== 1'b1) $display("FAIL turn_rd_ack: got %b want 1", o_hdr_ack); else n_pass++;
    n_chk++; if ({ce_n, oe_n, we_n} !== 3'b111) $display("FAIL turn_pins: got %b want 111", {ce_n, oe_n, we_n}); else n_pass++;
    next_cycle();
    hreq = 1'b0;
    @(negedge clk);
    n_chk++; if (oe_n !== 1'b0 || sram_addr !== 20'h12345)
      $display("FAIL hrd_pins: got oe_n %b addr %h", oe_n, sram_addr); else n_pass++;
    next_cycle();
    @(negedge clk);
    n_chk++; if (o_hdr_rvalid !== 1'b1 || o_hdr_rdata !== 16'hBEEF)
      $display("FAIL hrd_data: got v %b d %h want 1 beef", o_hdr_rvalid, o_hdr_rdata); else n_pass++;
    n_chk++; if (o_disp_valid !== 1'b0) $display("FAIL hrd_disp_strobe: got 1 want 0"); else n_pass++;
    next_cycle();
    @(negedge clk);
    n_chk++; if (o_hdr_rvalid !== 1'b0) $display("FAIL hrd_one_shot: got 1 want 0"); else n_pass++;
    next_cycle();
  endtask

  task automatic test_starvation();
    dreq = 1'b1; hreq = 1'b1; hwe = 1'b0; haddr = 20'h00777;
    for (int k = 0; k < 69; k++) begin
      daddr = 20'(k + 100);
      if (k == 65) haddr = 20'h00888;
      if (k == 66) hreq = 1'b0;
      if (k == 68) dreq = 1'b0;
      @(negedge clk);
      if (k <= 65) begin
        n_chk++; if (o_hdr_ack !== (k == 64)) $display("FAIL starve_ack k=%0d: got %b want %b", k, o_hdr_ack, (k == 64)); else n_pass++;
        n_chk++; if (o_disp_ready !== (k != 64)) $display("FAIL starve_ready k=%0d: got %b want %b", k, o_disp_ready, (k != 64)); else n_pass++;
      end
      if (k == 66) begin
        n_chk++; if (o_hdr_rvalid !== 1'b1 || o_hdr_rdata !== 16'h0777 || o_disp_valid !== 1'b0)
          $display("FAIL starve_hdr_data: got hv %b d %h dv %b", o_hdr_rvalid, o_hdr_rdata, o_disp_valid); else n_pass++;
      end
      if (k == 67) begin
        n_chk++; if (o_disp_valid !== 1'b1 || o_disp_data !== 16'd165)
          $display("FAIL starve_resume: got dv %b d %h want 1 00a5", o_disp_valid, o_disp_data); else n_pass++;
      end
      next_cycle();
    end
    for (int k = 0; k < 3; k++) next_cycle();
  endtask

  task automatic test_write_to_disp();
    hreq = 1'b1; hwe = 1'b1; haddr = 20'h54321; hwdata = 16'hA5C3; dreq = 1'b0;
    @(negedge clk);
    n_chk++; if (o_hdr_ack !== 1'b1) $display("FAIL w2d_wr_ack: got %b want 1", o_hdr_ack); else n_pass++;
    next_cycle();
    hreq = 1'b0; dreq = 1'b1; daddr = 20'h00042;
    @(negedge clk);
    n_chk++; if (o_disp_ready !== 1'b0) $display("FAIL w2d_ready_n1: got %b want 0", o_disp_ready); else n_pass++;
    next_cycle();
    @(negedge clk);
    n_chk++; if (o_disp_ready !== 1'b1 || ce_n !== 1'b1)
      $display("FAIL w2d_accept_n2: got ready %b ce_n %b want 1 1", o_disp_ready, ce_n); else n_pass++;
    next_cycle();
    dreq = 1'b0;
    @(negedge clk);
    n_chk++; if (oe_n !== 1'b0 || sram_addr !== 20'h00042)
      $display("FAIL w2d_pins_n3: got oe_n %b addr %h", oe_n, sram_addr); else n_pass++;
    next_cycle();
    @(negedge clk);
    n_chk++; if (o_disp_valid !== 1'b1 || o_disp_data !== 16'h0042)
      $display("FAIL w2d_valid_n4: got v %b d %h want 1 0042", o_disp_valid, o_disp_data); else n_pass++;
    next_cycle();
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    dreq = 1'b1; daddr = 20'h00005; hreq = 1'b0;
    @(negedge clk);
    n_chk++; if (o_disp_ready !== 1'b1) $display("FAIL rmr_accept: got %b want 1", o_disp_ready); else n_pass++;
    next_cycle();
    dreq = 1'b0; rst = 1'b1;
    @(negedge clk);
    n_chk++; if (oe_n !== 1'b0) $display("FAIL rmr_inflight: got oe_n %b want 0", oe_n); else n_pass++;
    n_chk++; if (o_disp_ready !== 1'b0) $display("FAIL rmr_ready_in_rst: got %b want 0", o_disp_ready); else n_pass++;
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_chk++; if (o_disp_valid !== 1'b0 || o_hdr_rvalid !== 1'b0 || o_disp_data !== 16'h0)
        $display("FAIL rmr_no_strobe k=%0d: got dv %b hv %b d %h", k, o_disp_valid, o_hdr_rvalid, o_disp_data); else n_pass++;
      n_chk++; if ({ce_n, oe_n, we_n} !== 3'b111) $display("FAIL rmr_pins k=%0d: got %b want 111", k, {ce_n, oe_n, we_n}); else n_pass++;
      next_cycle();
    end
  endtask

  typedef struct {int due; bit hdr; logic [15:0] d;} rd_t;

  task automatic test_random();
    logic [15:0] ref_mem [logic [19:0]];
    rd_t         q[$];
    bit          d_pend = 0, h_pend = 0, last_was_write = 0;
    int          waited = 0;
    bit          exp_ready, exp_ack, exp_dv, exp_hv;
    logic [15:0] exp_dd, exp_hd;
    dreq = 1'b0; hreq = 1'b0;
    for (int t = 0; t < 2020; t++) begin
      if (t < 2000) begin
        if (!d_pend && (t < 800 || $urandom_range(0, 1) == 0)) begin
          d_pend = 1; daddr = 20'($urandom_range(0, 31));
        end
        if (!h_pend && $urandom_range(0, 2) == 0) begin
          h_pend = 1; hwe = 1'($urandom_range(0, 1));
          haddr = 20'($urandom_range(0, 31)); hwdata = 16'($urandom);
        end
      end
      dreq = d_pend; hreq = h_pend;
      @(negedge clk);
      exp_ready = !last_was_write && !(waited >= STARVE && hreq);
      exp_ack   = hreq && (last_was_write ? hwe : (waited >= STARVE || !dreq));
      exp_dv = 0; exp_hv = 0; exp_dd = '0; exp_hd = '0;
      if (q.size() != 0 && q[0].due == cyc) begin
        if (q[0].hdr) begin exp_hv = 1; exp_hd = q[0].d; end
        else          begin exp_dv = 1; exp_dd = q[0].d; end
        void'(q.pop_front());
      end
      n_chk++; if (o_disp_ready !== exp_ready) $display("FAIL rnd_ready t=%0d: got %b want %b", t, o_disp_ready, exp_ready); else n_pass++;
      n_chk++; if (o_hdr_ack !== exp_ack) $display("FAIL rnd_ack t=%0d: got %b want %b", t, o_hdr_ack, exp_ack); else n_pass++;
      n_chk++; if (o_disp_valid !== exp_dv || (exp_dv && o_disp_data !== exp_dd))
        $display("FAIL rnd_disp t=%0d: got v %b d %h want v %b d %h", t, o_disp_valid, o_disp_data, exp_dv, exp_dd); else n_pass++;
      n_chk++; if (o_hdr_rvalid !== exp_hv || (exp_hv && o_hdr_rdata !== exp_hd))
        $display("FAIL rnd_hdr t=%0d: got v %b d %h want v %b d %h", t, o_hdr_rvalid, o_hdr_rdata, exp_hv, exp_hd); else n_pass++;
      if (dreq && exp_ready) begin
        q.push_back('{cyc + 2, 1'b0, ref_mem.exists(daddr) ? ref_mem[daddr] : daddr[15:0]});
        d_pend = 0;
      end
      if (exp_ack) begin
        if (hwe) ref_mem[haddr] = hwdata;
        else q.push_back('{cyc + 2, 1'b1, ref_mem.exists(haddr) ? ref_mem[haddr] : haddr[15:0]});
        h_pend = 0;
      end
      last_was_write = exp_ack && hwe;
      waited = (hreq && !exp_ack) ? waited + 1 : 0;
      next_cycle();
    end
    dreq = 1'b0; hreq = 1'b0;
  endtask

  initial begin
    test_reset();
    test_disp_burst();
    test_hdr_write_read();
    test_starvation();
    test_write_to_disp();
    test_reset_mid_read();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
